sprite_motion_ctrl: RTL and testbench

//  Per-frame motion scheduler for the player square in the 640x480 VGA path.

---
 rtl/sprite_motion_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Per-frame motion scheduler for the player square: screen-bound check, then one wall entry
// per cycle, then a position commit. Tick to done is WALL_NUM+3 cycles; ticks while busy are dropped and flagged.
module sprite_motion_ctrl #(
    parameter int WALL_NUM = 4,
    parameter int SQ_LEN   = 20,
    parameter int STEP     = 2,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 100,
    parameter int SCR_L    = 1,
    parameter int SCR_R    = 639,
    parameter int SCR_T    = 1,
    parameter int SCR_B    = 479
) (
    input  logic        i_pixel_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_tick,
    input  logic        i_up,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_wall_we,
    input  logic [3:0]  i_wall_idx,
    input  logic        i_wall_valid,
    input  logic [10:0] i_wall_hmin,
    input  logic [10:0] i_wall_hmax,
    input  logic [10:0] i_wall_vmin,
    input  logic [10:0] i_wall_vmax,
    output logic [10:0] o_pos_x,
    output logic [10:0] o_pos_y,
    output logic        o_coll_x,
    output logic        o_coll_y,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun
);

    typedef enum logic [1:0] {IDLE, SCREEN, SCAN, COMMIT} state_t;

    localparam logic signed [11:0] L_SQ    = 12'(SQ_LEN);
    localparam logic signed [11:0] L_STEP  = 12'(STEP);
    localparam logic signed [11:0] L_SCR_L = 12'(SCR_L);
    localparam logic signed [11:0] L_SCR_R = 12'(SCR_R);
    localparam logic signed [11:0] L_SCR_T = 12'(SCR_T);
    localparam logic signed [11:0] L_SCR_B = 12'(SCR_B);
    localparam logic [4:0]         L_WN    = 5'(WALL_NUM);
    localparam logic [3:0]         L_LAST  = 4'(WALL_NUM - 1);

    state_t             r_state, w_next;
    logic [10:0]        r_pos_x, r_pos_y;
    logic signed [11:0] r_vx, r_vy;
    logic               r_cx, r_cy, r_coll_x, r_coll_y, r_done, r_overrun;
    logic [3:0]         r_idx;

    // Table is sized for the full 4-bit index; entries at or above WALL_NUM stay invalid.
    logic               r_wvld [16];
    logic [10:0]        r_hmin [16];
    logic [10:0]        r_hmax [16];
    logic [10:0]        r_vmin [16];
    logic [10:0]        r_vmax [16];

    logic signed [11:0] w_x, w_y, w_nx, w_ny, w_hmin, w_hmax, w_vmin, w_vmax;
    logic               w_scr_cx, w_scr_cy, w_wall_cx, w_wall_cy, w_wr;

    assign w_x    = $signed({1'b0, r_pos_x});
    assign w_y    = $signed({1'b0, r_pos_y});
    assign w_nx   = w_x + r_vx;
    assign w_ny   = w_y + r_vy;
    assign w_hmin = $signed({1'b0, r_hmin[r_idx]});
    assign w_hmax = $signed({1'b0, r_hmax[r_idx]});
    assign w_vmin = $signed({1'b0, r_vmin[r_idx]});
    assign w_vmax = $signed({1'b0, r_vmax[r_idx]});

    assign w_scr_cx  = (w_nx <= L_SCR_L) || (w_nx + L_SQ >= L_SCR_R);
    assign w_scr_cy  = (w_ny <= L_SCR_T) || (w_ny + L_SQ >= L_SCR_B);
    // Each axis tests its own move while the other axis stays at the current position.
    assign w_wall_cx = r_wvld[r_idx] && (w_nx <= w_hmax) && (w_nx + L_SQ >= w_hmin)
                       && (w_y + L_SQ >= w_vmin) && (w_y <= w_vmax);
    assign w_wall_cy = r_wvld[r_idx] && (w_x <= w_hmax) && (w_x + L_SQ >= w_hmin)
                       && (w_ny + L_SQ >= w_vmin) && (w_ny <= w_vmax);

    assign w_wr = i_wall_we && (r_state == IDLE) && !i_frame_tick
                  && ({1'b0, i_wall_idx} < L_WN);

    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_frame_tick) w_next = SCREEN;
            SCREEN:  w_next = SCAN;
            SCAN:    if (r_idx == L_LAST) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos_x   <= 11'(X_INIT);
            r_pos_y   <= 11'(Y_INIT);
            r_vx      <= '0;
            r_vy      <= '0;
            r_cx      <= 1'b0;
            r_cy      <= 1'b0;
            r_coll_x  <= 1'b0;
            r_coll_y  <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_idx     <= '0;
            for (int i = 0; i < 16; i++) begin
                r_wvld[i] <= 1'b0;
                r_hmin[i] <= '0;
                r_hmax[i] <= '0;
                r_vmin[i] <= '0;
                r_vmax[i] <= '0;
            end
            r_wvld[0] <= 1'b1;
            r_hmin[0] <= 11'd300;
            r_hmax[0] <= 11'd340;
            r_vmin[0] <= 11'd200;
            r_vmax[0] <= 11'd400;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= i_frame_tick && (r_state != IDLE);
            case (r_state)
                IDLE: if (i_frame_tick) begin
                    r_vy <= i_up ? -L_STEP : (i_down  ? L_STEP : '0);
                    r_vx <= i_left ? -L_STEP : (i_right ? L_STEP : '0);
                    r_cx <= 1'b0;
                    r_cy <= 1'b0;
                end
                SCREEN: begin
                    r_cx  <= r_cx | w_scr_cx;
                    r_cy  <= r_cy | w_scr_cy;
                    r_idx <= '0;
                end
                SCAN: begin
                    r_cx  <= r_cx | w_wall_cx;
                    r_cy  <= r_cy | w_wall_cy;
                    r_idx <= r_idx + 4'd1;
                end
                COMMIT: begin
                    if (!r_cx) r_pos_x <= w_nx[10:0];
                    if (!r_cy) r_pos_y <= w_ny[10:0];
                    r_coll_x <= r_cx;
                    r_coll_y <= r_cy;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
            if (w_wr) begin
                r_wvld[i_wall_idx] <= i_wall_valid;
                r_hmin[i_wall_idx] <= i_wall_hmin;
                r_hmax[i_wall_idx] <= i_wall_hmax;
                r_vmin[i_wall_idx] <= i_wall_vmin;
                r_vmax[i_wall_idx] <= i_wall_vmax;
            end
        end
    end

    assign o_pos_x   = r_pos_x;
    assign o_pos_y   = r_pos_y;
    assign o_coll_x  = r_coll_x;
    assign o_coll_y  = r_coll_y;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = r_done;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed frames with a scoreboard of expected commits,
// popped by a monitor on every done pulse.
module tb_sprite_motion_ctrl;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        cx;
        logic        cy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic        we = 1'b0, wvalid = 1'b0;
    logic [3:0]  widx = '0;
    logic [10:0] whmin = '0, whmax = '0, wvmin = '0, wvmax = '0;
    logic [10:0] o_pos_x, o_pos_y;
    logic        o_coll_x, o_coll_y, o_busy, o_done, o_overrun;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0, n_done = 0, n_push = 0, n_ovr = 0;
    int   cur_x = 100, cur_y = 100;
    int   m_vld[4], m_hmin[4], m_hmax[4], m_vmin[4], m_vmax[4];

    sprite_motion_ctrl dut (
        .i_pixel_clk (clk),
        .i_rst_n     (rst_n),
        .i_frame_tick(tick),
        .i_up        (up),
        .i_down      (down),
        .i_left      (left),
        .i_right     (right),
        .i_wall_we   (we),
        .i_wall_idx  (widx),
        .i_wall_valid(wvalid),
        .i_wall_hmin (whmin),
        .i_wall_hmax (whmax),
        .i_wall_vmin (wvmin),
        .i_wall_vmax (wvmax),
        .o_pos_x     (o_pos_x),
        .o_pos_y     (o_pos_y),
        .o_coll_x    (o_coll_x),
        .o_coll_y    (o_coll_y),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_overrun   (o_overrun)
    );

    always #20 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    function automatic exp_t mk(input int x, input int y, input int cx, input int cy);
        exp_t e;
        e.x = 11'(x); e.y = 11'(y); e.cx = 1'(cx); e.cy = 1'(cy);
        return e;
    endfunction

    task automatic tbl_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 0; m_hmin[i] = 0; m_hmax[i] = 0; m_vmin[i] = 0; m_vmax[i] = 0;
        end
        m_vld[0] = 1; m_hmin[0] = 300; m_hmax[0] = 340; m_vmin[0] = 200; m_vmax[0] = 400;
    endtask

    // Reference: one whole frame update straight from the behavioural description.
    function automatic exp_t model(input int x, input int y, input logic u, d, l, r);
        int vx, vy;
        bit cx, cy;
        vy = u ? -2 : (d ? 2 : 0);
        vx = l ? -2 : (r ? 2 : 0);
        cx = (x + vx <= 1) || (x + vx + 20 >= 639);
        cy = (y + vy <= 1) || (y + vy + 20 >= 479);
        for (int i = 0; i < 4; i++) begin
            if (m_vld[i] != 0) begin
                cx |= (x + vx <= m_hmax[i]) && (x + vx + 20 >= m_hmin[i])
                      && (y + 20 >= m_vmin[i]) && (y <= m_vmax[i]);
                cy |= (x <= m_hmax[i]) && (x + 20 >= m_hmin[i])
                      && (y + vy + 20 >= m_vmin[i]) && (y + vy <= m_vmax[i]);
            end
        end
        return mk(cx ? x : x + vx, cy ? y : y + vy, int'(cx), int'(cy));
    endfunction

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!o_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_done) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic frame(input logic u, d, l, r, input exp_t e);
        push(e);
        @(negedge clk);
        up = u; down = d; left = l; right = r; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_done("frame");
        cur_x = int'(e.x);
        cur_y = int'(e.y);
    endtask

    task automatic move(input logic u, d, l, r, input int n);
        for (int k = 0; k < n; k++) frame(u, d, l, r, model(cur_x, cur_y, u, d, l, r));
    endtask

    task automatic write_wall(input int idx, input int v, input int h0, input int h1,
                              input int v0, input int v1, input bit mirror);
        @(negedge clk);
        we = 1'b1; widx = 4'(idx); wvalid = 1'(v);
        whmin = 11'(h0); whmax = 11'(h1); wvmin = 11'(v0); wvmax = 11'(v1);
        @(negedge clk);
        we = 1'b0;
        if (mirror && idx < 4) begin
            m_vld[idx] = v; m_hmin[idx] = h0; m_hmax[idx] = h1; m_vmin[idx] = v0; m_vmax[idx] = v1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_done) begin
            n_done++;
            if (exp_q.size() == 0) chk("sb_nonempty", 0, 1);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pos_x", int'(o_pos_x), int'(e.x));
                chk("pos_y", int'(o_pos_y), int'(e.y));
                chk("coll_x", int'(o_coll_x), int'(e.cx));
                chk("coll_y", int'(o_coll_y), int'(e.cy));
            end
        end
        if (rst_n && o_overrun) n_ovr++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_cnt;
        tbl_reset();
        repeat (3) @(negedge clk);
        chk("rst_pos_x", int'(o_pos_x), 100);
        chk("rst_pos_y", int'(o_pos_y), 100);
        chk("rst_coll", int'({o_coll_x, o_coll_y}), 0);
        chk("rst_flags", int'({o_busy, o_done, o_overrun}), 0);
        rst_n = 1'b1;

        // Tick to done latency and busy window.
        push(mk(102, 100, 0, 0));
        @(negedge clk);
        right = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        n = 1; busy_cnt = 0;
        while (!o_done && n < 20) begin
            busy_cnt += int'(o_busy);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 7);
        chk("busy_cycles", busy_cnt, 6);
        chk("busy_after_done", int'(o_busy), 0);
        @(negedge clk);
        cur_x = 102;

        // Left screen edge, up beats down.
        move(1'b0, 1'b0, 1'b1, 1'b0, 50);
        frame(1'b1, 1'b1, 1'b1, 1'b0, mk(2, 98, 1, 0));

        // Wall 0 on the right; then an already-overlapping wall with no motion.
        move(1'b0, 1'b1, 1'b0, 1'b0, 76);
        move(1'b0, 1'b0, 1'b0, 1'b1, 138);
        frame(1'b0, 1'b0, 1'b0, 1'b1, mk(278, 250, 1, 0));
        write_wall(1, 1, 270, 290, 240, 260, 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, mk(278, 250, 1, 1));
        write_wall(1, 0, 270, 290, 240, 260, 1'b1);

        // Programmable entry blocks the vertical move until cleared.
        move(1'b0, 1'b0, 1'b1, 1'b0, 89);
        move(1'b1, 1'b0, 1'b0, 1'b0, 94);
        write_wall(2, 1, 100, 120, 50, 60, 1'b1);
        frame(1'b1, 1'b0, 1'b0, 1'b0, mk(100, 62, 0, 1));
        write_wall(2, 0, 100, 120, 50, 60, 1'b1);
        frame(1'b1, 1'b0, 1'b0, 1'b0, mk(100, 60, 0, 0));

        // Second tick while busy: one overrun pulse, one update.
        push(mk(100, 62, 0, 0));
        @(negedge clk);
        up = 1'b0; down = 1'b1; left = 1'b0; right = 1'b0; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("overrun_pulse", int'(o_overrun), 1);
        wait_done("overrun_frame");
        repeat (12) @(negedge clk);
        cur_x = 100; cur_y = 62;

        // Write during SCAN is dropped.
        push(mk(102, 62, 0, 0));
        @(negedge clk);
        down = 1'b0; right = 1'b1; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        we = 1'b1; widx = 4'd3; wvalid = 1'b1;
        whmin = 11'd0; whmax = 11'd639; wvmin = 11'd0; wvmax = 11'd479;
        @(negedge clk); we = 1'b0;
        wait_done("scan_write_frame");
        frame(1'b0, 1'b0, 1'b0, 1'b1, mk(104, 62, 0, 0));
        write_wall(1, 1, 0, 639, 0, 479, 1'b1);
        frame(1'b0, 1'b0, 1'b0, 1'b1, mk(104, 62, 1, 1));

        // Reset in the middle of SCAN.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_pos_x", int'(o_pos_x), 100);
        chk("arst_pos_y", int'(o_pos_y), 100);
        chk("arst_coll", int'({o_coll_x, o_coll_y}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tbl_reset();
        cur_x = 100; cur_y = 100;

        // Out-of-range index ignored; table back to reset contents.
        write_wall(5, 1, 0, 639, 0, 479, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b1, mk(102, 100, 0, 0));

        repeat (12) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        chk("done_count", n_done, n_push);
        chk("overrun_count", n_ovr, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
